// File: rtl/id_pkg.sv
// Shared definitions for the ID pipe buffer: default widths, field offsets,
// bubble constant and the queued entry layout.
package id_pkg;

  localparam int IW_D    = 16;
  localparam int PCW_D   = 6;
  localparam int RAW_D   = 4;
  localparam int OPW_D   = 4;
  localparam int DEPTH_D = 4;

  function automatic int imm_width(input int iw, input int opw, input int raw);
    return iw - opw - 2 * raw;
  endfunction

  function automatic int op1_lsb(input int iw, input int opw, input int raw);
    return iw - opw - raw;
  endfunction

  function automatic int op2_lsb(input int iw, input int opw, input int raw);
    return imm_width(iw, opw, raw);
  endfunction

  localparam int IMMW_D    = imm_width(IW_D, OPW_D, RAW_D);
  localparam int OP1_LSB_D = op1_lsb(IW_D, OPW_D, RAW_D);
  localparam int OP2_LSB_D = op2_lsb(IW_D, OPW_D, RAW_D);

  typedef struct packed {
    logic [PCW_D-1:0] pc;
    logic [IW_D-1:0]  instr;
  } entry_t;

  localparam entry_t BUBBLE = '0;

endpackage

// File: rtl/id_fifo_core.sv
// Queue storage for the ID pipe buffer: circular buffer with read/write
// pointers, occupancy count, and a flush that empties it in one cycle.
module id_fifo_core
  import id_pkg::*;
#(
  parameter int WIDTH = IW_D + PCW_D,
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Guard locally so the count can never leave 0..DEPTH whatever the caller does.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/id_pipe_buf.sv
// IF/ID instruction queue with hazard bubbles and flush. Optional same-cycle
// forwarding into an empty queue is enabled by defining ID_PIPE_BUF_BYPASS_EN.
module id_pipe_buf
  import id_pkg::*;
#(
  parameter int IW    = IW_D,
  parameter int PCW   = PCW_D,
  parameter int RAW   = RAW_D,
  parameter int OPW   = OPW_D,
  parameter int DEPTH = DEPTH_D,
  localparam int IMMW = imm_width(IW, OPW, RAW),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_valid,
  output logic            out_ready,
  input  logic [IW-1:0]   in_instr,
  input  logic [PCW-1:0]  in_pc,
  input  logic            in_haz,
  input  logic            in_flush,
  input  logic            in_id_ready,
  output logic            out_valid,
  output logic [IW-1:0]   out_instr,
  output logic [PCW-1:0]  out_pc,
  output logic [RAW-1:0]  out_op1_addr,
  output logic [RAW-1:0]  out_op2_addr,
  output logic [IMMW-1:0] out_imm,
  output logic            out_rst,
  output logic [CW-1:0]   out_count
);

  localparam int EW = IW + PCW;

  if (IMMW < 1) begin : g_bad_imm
    $error("id_pipe_buf: immediate field width must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("id_pipe_buf: DEPTH must be a power of two >= 2");
  end

  logic [EW-1:0] head;
  logic [EW-1:0] sel;
  logic [EW-1:0] shown;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          show;

  id_fifo_core #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (in_clk),
    .rst  (in_rst),
    .flush(in_flush),
    .push (push),
    .pop  (pop),
    .wdata({in_pc, in_instr}),
    .rdata(head),
    .count(out_count),
    .full (full),
    .empty(empty)
  );

`ifdef ID_PIPE_BUF_BYPASS_EN
  logic byp;

  always_comb begin
    byp  = empty && in_valid && !in_haz && !in_flush;
    show = (!empty || byp) && !in_haz;
    sel  = empty ? {in_pc, in_instr} : head;
    // A forwarded instruction that decode takes right away never occupies a slot.
    push = in_valid && !full && !in_flush && !(byp && in_id_ready);
    pop  = !empty && !in_haz && !in_flush && in_id_ready;
  end
`else
  always_comb begin
    show = !empty && !in_haz;
    sel  = head;
    push = in_valid && !full && !in_flush;
    pop  = show && in_id_ready && !in_flush;
  end
`endif

  assign shown        = show ? sel : {EW{1'b0}};
  assign out_ready    = !full;
  assign out_valid    = show;
  assign out_rst      = !show;
  assign out_instr    = shown[IW-1:0];
  assign out_pc       = shown[EW-1:IW];
  assign out_op1_addr = out_instr[IW-OPW-1 -: RAW];
  assign out_op2_addr = out_instr[IW-OPW-RAW-1 -: RAW];
  assign out_imm      = out_instr[IMMW-1:0];

endmodule

// File: doc/id_pipe_buf.md
Name: id_pipe_buf

Overview:
- Parametrised, registered successor to the IF/ID decode buffer: a DEPTH-entry instruction queue between fetch and decode.
- Fetch side uses a valid/ready handshake. Decode side presents the head entry, split into fields (instruction, PC, op1/op2 addresses, immediate).
- Hazard stall holds the queue and drives a zeroed bubble. Flush (branch/jump) discards all queued entries.

Parameters:
- IW, 16, instruction width.
- PCW, 6, PC/adder width carried alongside each instruction.
- RAW, 4, register address field width.
- OPW, 4, opcode field width. Immediate width IMMW = IW-OPW-2*RAW, which must be ≥1.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- in_clk  input  1  single clock, rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- out_ready  output  1  queue can accept (not full).
- in_instr  input  IW  fetched instruction.
- in_pc  input  PCW  adder1 output paired with in_instr.
- in_haz  input  1  hazard stall from hazard unit.
- in_flush  input  1  discard all entries.
- in_id_ready  input  1  decode consumes the head this cycle.
- out_valid  output  1  head entry valid and not stalled.
- out_instr  output  IW  head instruction, to hazard unit and control logic.
- out_pc  output  PCW  head PC, to adder2.
- out_op1_addr  output  RAW  instr[IW-OPW-1 -: RAW].
- out_op2_addr  output  RAW  instr[IW-OPW-RAW-1 -: RAW].
- out_imm  output  IMMW  instr[IMMW-1:0].
- out_rst  output  1  bubble indicator: 1 whenever outputs carry a bubble.
- out_count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- **Reset** (in_rst=1 at edge): pointers and count cleared. Next cycle: out_valid=0, out_rst=1, all data outputs 0, out_ready=1. Reset dominates flush, push and pop.
- **Push**: on edge when in_valid && out_ready && !in_flush; writes {in_pc, in_instr} at the write pointer.
- **Pop**: on edge when out_valid && in_id_ready, i.e. head present, in_haz=0, in_flush=0.
- **Latency**: an entry pushed into an empty queue appears on the outputs the next cycle.
- **Simultaneous push and pop**:
  - When full: push is refused, since out_ready=0 that cycle; no same-cycle slot reuse.
  - Otherwise: count unchanged.
- **Pointers**: wrap modulo DEPTH. Count saturates at DEPTH and never exceeds it. out_ready = (count != DEPTH).
- **Hazard** (in_haz=1):
  - Combinationally, same cycle: out_valid=0, out_rst=1, out_instr/out_pc/out_op1_addr/out_op2_addr/out_imm all 0.
  - No pop occurs; pushes continue while not full.
  - Head contents are preserved and reappear when in_haz returns to 0.
- **Flush** (in_flush=1 at edge):
  - count := 0 and pointers reset; the same-cycle push is dropped.
  - Next cycle matches the post-reset state.
  - Flush together with in_haz: flush wins for queue state.
- **Empty, no hazard**: out_valid=0, out_rst=1, data outputs 0.
- **Non-empty, no hazard**: out_valid=1, out_rst=0, fields decoded combinationally from the registered head.

Optional Feature:
- Macro ID_PIPE_BUF_BYPASS_EN.
- **Defined**: when the queue is empty, in_valid=1, in_haz=0 and in_flush=0, the incoming instruction is forwarded combinationally to the outputs (out_valid=1). If in_id_ready=1 the entry is consumed without being written; otherwise it is written normally.
- **Undefined**: strict 1-cycle latency as described in Behaviour.

Decomposition:
- Shared package id_pkg holds:
  - field offset/width localparams derived from IW/OPW/RAW;
  - the bubble constant (all zeros);
  - an entry typedef {pc, instr}.
- One natural sub-module, id_fifo_core: storage, pointers and count with push, pop and flush.
- Field slicing and hazard/bubble muxing stay in the top module.

Test Plan:
- Reset, then push 16'h1234 with pc 6'h05 → next cycle: out_valid=1, out_op1_addr=4'h2, out_op2_addr=4'h3, out_imm=4'h4, out_pc=6'h05, out_rst=0.
- Push 4 entries with in_id_ready=0 → out_count=4, out_ready=0. A 5th push is ignored. Pop all 4 → values in FIFO order; pointers wrap correctly on a refill.
- Head 16'hABCD, then in_haz=1 for 3 cycles → outputs all 0, out_rst=1, out_count unchanged. in_haz=0 → 16'hABCD is presented again.
- 3 entries queued, in_flush=1 together with a push of 16'h7777 → next cycle out_count=0, out_valid=0; 16'h7777 never appears.
- in_rst=1 asserted with a full queue and in_haz=1 → next cycle out_count=0, out_ready=1, out_rst=1, data outputs 0.
- ID_PIPE_BUF_BYPASS_EN defined, empty queue, push 16'h0F0F with in_id_ready=1 → same-cycle out_valid=1 with out_instr=16'h0F0F, and next cycle out_count=0.
